loop_reduce_pipe: RTL and testbench

LOOP_REDUCE_PIPE -- requirements
Module: loop_reduce_pipe

---
 rtl/loop_reduce_pipe_if.sv | 27 ++
 rtl/loop_reduce_pipe.sv | 152 +++++++++++++++
 tb/tb_loop_reduce_pipe.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/loop_reduce_pipe_if.sv
// Handshake bundle for loop_reduce_pipe.
// Input stream (q/r/offset_en) and output stream (sign/mag/sat).
interface loop_reduce_pipe_if #(
    parameter int WIDTH = 8,
    parameter int LANES = 4
);
    logic                         in_valid;
    logic                         in_ready;
    logic [LANES*WIDTH-1:0]       q_in;
    logic [LANES*WIDTH-1:0]       r_in;
    logic                         offset_en;
    logic                         out_valid;
    logic                         out_ready;
    logic [LANES-1:0]             sign_out;
    logic [LANES*(WIDTH-1)-1:0]   mag_out;
    logic [LANES-1:0]             sat_out;

    modport master (
        output in_valid, q_in, r_in, offset_en, out_ready,
        input  in_ready, out_valid, sign_out, mag_out, sat_out
    );

    modport slave (
        input  in_valid, q_in, r_in, offset_en, out_ready,
        output in_ready, out_valid, sign_out, mag_out, sat_out
    );
endinterface

// File: rtl/loop_reduce_pipe.sv
// Two-stage variable-node update: d = q - r, sign/magnitude split,
// saturation and optional offset-min-sum correction per lane.
module loop_reduce_pipe #(
    parameter int          WIDTH  = 8,
    parameter int          LANES  = 4,
    parameter int unsigned OFFSET = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                clr_cnt,
    loop_reduce_pipe_if.slave   bus,
    output logic [15:0]         sat_cnt
);
    localparam int DW = WIDTH + 1;
    localparam int MW = WIDTH - 1;
    localparam logic [DW-1:0] MAXM = DW'((32'd1 << MW) - 32'd1);

    logic                  s1_valid;
    logic                  s1_off;
    logic [LANES*DW-1:0]   s1_d;
    logic                  s2_valid;
    logic [LANES-1:0]      s2_sign;
    logic [LANES*MW-1:0]   s2_mag;
    logic [LANES-1:0]      s2_sat;

    logic                  s2_load;
    logic                  accept;
    logic [LANES*DW-1:0]   d_in;
    logic [LANES-1:0]      sign_c;
    logic [LANES-1:0]      sat_c;
    logic [LANES*MW-1:0]   mag_c;
    logic [16:0]           cnt_sum;

    assign bus.out_valid = s2_valid;
    assign bus.sign_out  = s2_sign;
    assign bus.mag_out   = s2_mag;
    assign bus.sat_out   = s2_sat;

    // Handshake: S2 loads when it is free or drained; flush blocks everything.
    always_comb begin
        s2_load      = s1_valid && (!s2_valid || bus.out_ready) && !flush;
        bus.in_ready = (!s1_valid || s2_load) && !flush;
        accept       = bus.in_valid && bus.in_ready;
    end

    // Sign-extended lane difference; WIDTH+1 bits cannot overflow.
    always_comb begin
        d_in = '0;
        for (int k = 0; k < LANES; k++) begin
            d_in[k*DW +: DW] =
                {bus.q_in[k*WIDTH+WIDTH-1], bus.q_in[k*WIDTH +: WIDTH]} -
                {bus.r_in[k*WIDTH+WIDTH-1], bus.r_in[k*WIDTH +: WIDTH]};
        end
    end

    // Magnitude, saturation (checked before offset) and offset correction.
    always_comb begin
        logic [DW-1:0] d;
        logic [DW-1:0] a;
        logic [MW-1:0] m;
        d      = '0;
        a      = '0;
        m      = '0;
        sign_c = '0;
        sat_c  = '0;
        mag_c  = '0;
        for (int k = 0; k < LANES; k++) begin
            d         = s1_d[k*DW +: DW];
            a         = d[DW-1] ? DW'(~d + DW'(1)) : d;
            sign_c[k] = d[DW-1];
            if (a > MAXM) begin
                sat_c[k] = 1'b1;
                m        = MAXM[MW-1:0];
            end else begin
                m        = a[MW-1:0];
            end
            if (s1_off) begin
                if ({{(32-MW){1'b0}}, m} > OFFSET)
                    m = m - MW'(OFFSET);
                else
                    m = '0;
            end
            mag_c[k*MW +: MW] = m;
        end
    end

    // Saturated-lane count for this load, widened to catch the ceiling.
    always_comb begin
        cnt_sum = {1'b0, sat_cnt};
        for (int k = 0; k < LANES; k++)
            cnt_sum = cnt_sum + 17'(sat_c[k]);
    end

    // S1 occupancy: flush wins, then accept, then hand-off to S2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            s1_valid <= 1'b0;
        else if (flush)
            s1_valid <= 1'b0;
        else if (accept)
            s1_valid <= 1'b1;
        else if (s2_load)
            s1_valid <= 1'b0;
    end

    // S1 data only moves on accept so a stalled stage holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_d   <= '0;
            s1_off <= 1'b0;
        end else if (accept) begin
            s1_d   <= d_in;
            s1_off <= bus.offset_en;
        end
    end

    // S2 occupancy: refill keeps it valid, consumption empties it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            s2_valid <= 1'b0;
        else if (flush)
            s2_valid <= 1'b0;
        else if (s2_load)
            s2_valid <= 1'b1;
        else if (bus.out_ready)
            s2_valid <= 1'b0;
    end

    // S2 result registers, stable while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_sign <= '0;
            s2_mag  <= '0;
            s2_sat  <= '0;
        end else if (s2_load) begin
            s2_sign <= sign_c;
            s2_mag  <= mag_c;
            s2_sat  <= sat_c;
        end
    end

    // Saturating counter of saturated lanes; clear beats increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sat_cnt <= '0;
        else if (clr_cnt)
            sat_cnt <= '0;
        else if (s2_load)
            sat_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end
endmodule

// File: tb/tb_loop_reduce_pipe.sv
// Bench for loop_reduce_pipe: directed table, backpressure, flush,
// reset and randomized traffic against an arithmetic reference model.
module tb_loop_reduce_pipe;
    localparam int W   = 8;
    localparam int L   = 4;
    localparam int MW  = W - 1;
    localparam int OFF = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        clr_cnt = 1'b0;
    logic [15:0] sat_cnt;

    loop_reduce_pipe_if #(.WIDTH(W), .LANES(L)) bus ();

    loop_reduce_pipe #(.WIDTH(W), .LANES(L), .OFFSET(OFF)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .clr_cnt (clr_cnt),
        .bus     (bus),
        .sat_cnt (sat_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [L-1:0]    sign;
        logic [L*MW-1:0] mag;
        logic [L-1:0]    sat;
    } res_t;

    typedef struct {
        logic [L*W-1:0]  q;
        logic [L*W-1:0]  r;
        bit              off;
        logic [L-1:0]    sign;
        logic [L*MW-1:0] mag;
        logic [L-1:0]    sat;
    } vec_t;

    res_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          exp_cnt = 0;
    int          n_acc = 0;
    int          n_out = 0;
    logic        obs_valid;
    logic        obs_ready;
    res_t        obs;
    logic [15:0] obs_cnt;
    bit          hold = 0;
    res_t        hold_res;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [L*W-1:0] pk8(input int a, b, c, d);
        logic [L*W-1:0] v;
        v = {8'(d), 8'(c), 8'(b), 8'(a)};
        return v;
    endfunction

    function automatic logic [L*MW-1:0] pk7(input int a, b, c, d);
        logic [L*MW-1:0] v;
        v = {7'(d), 7'(c), 7'(b), 7'(a)};
        return v;
    endfunction

    function automatic res_t model(input logic [L*W-1:0] q, r, input bit off);
        res_t x;
        x = '0;
        for (int k = 0; k < L; k++) begin
            int d, a, m, lim;
            lim = (1 << (W - 1)) - 1;
            d = int'($signed(q[k*W +: W])) - int'($signed(r[k*W +: W]));
            a = (d < 0) ? -d : d;
            x.sign[k] = (d < 0);
            x.sat[k]  = (a > lim);
            m = (a > lim) ? lim : a;
            if (off) m = (m > OFF) ? m - OFF : 0;
            x.mag[k*MW +: MW] = MW'(m);
        end
        return x;
    endfunction

    task automatic cycle(input bit iv, input logic [L*W-1:0] q, r,
                         input bit off, input bit ordy, input bit fl,
                         input bit clr, output bit acc);
        res_t e;
        @(negedge clk);
        bus.in_valid  = iv;
        bus.q_in      = q;
        bus.r_in      = r;
        bus.offset_en = off;
        bus.out_ready = ordy;
        flush         = fl;
        clr_cnt       = clr;
        #1;
        obs_valid = bus.out_valid;
        obs_ready = bus.in_ready;
        obs       = {bus.sign_out, bus.mag_out, bus.sat_out};
        obs_cnt   = sat_cnt;
        acc       = iv && bus.in_ready;
        if (hold) begin
            chk("hold_valid", obs_valid, 1);
            chk("hold_data", obs, hold_res);
        end
        if (fl) begin
            chk("flush_in_ready", obs_ready, 0);
            sb.delete();
            hold = 0;
        end else begin
            if (obs_valid && ordy) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out got %0h want none", obs);
                end else begin
                    e = sb.pop_front();
                    chk("sb_data", obs, e);
                    n_out++;
                    exp_cnt += $countones(e.sat);
                end
            end
            if (acc) begin
                sb.push_back(model(q, r, off));
                n_acc++;
            end
            hold     = obs_valid && !ordy;
            hold_res = obs;
        end
        @(posedge clk);
    endtask

    task automatic idle(input bit ordy);
        bit a;
        cycle(0, '0, '0, 0, ordy, 0, 0, a);
    endtask

    task automatic drain();
        for (int i = 0; i < 30; i++) begin
            if (sb.size() == 0 && !bus.out_valid) break;
            idle(1);
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    vec_t           tbl[5];
    logic [L*W-1:0] bq[5];
    logic [L*W-1:0] br[5];

    initial begin
        bit          acc;
        int          idx;
        int          n0;
        logic [15:0] c0;

        bus.in_valid  = 0;
        bus.q_in      = '0;
        bus.r_in      = '0;
        bus.offset_en = 0;
        bus.out_ready = 0;

        tbl[0] = '{pk8(10, 3, 5, -128), pk8(3, 10, 5, -128), 0,
                   4'b0010, pk7(7, 7, 0, 0), 4'b0000};
        tbl[1] = '{pk8(127, -128, 0, 0), pk8(-128, 127, 0, 0), 0,
                   4'b0010, pk7(127, 127, 0, 0), 4'b0011};
        tbl[2] = '{pk8(1, 0, 0, 50), pk8(0, 1, 0, 0), 1,
                   4'b0010, pk7(0, 0, 0, 49), 4'b0000};
        tbl[3] = '{pk8(127, -127, 127, -128), pk8(0, 0, -1, 0), 0,
                   4'b1010, pk7(127, 127, 127, 127), 4'b1100};
        tbl[4] = '{pk8(127, 2, -3, 100), pk8(-128, 0, 0, 100), 1,
                   4'b0100, pk7(126, 1, 2, 0), 4'b0001};

        // reset values
        repeat (2) @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_sign", bus.sign_out, 0);
        chk("rst_mag", bus.mag_out, 0);
        chk("rst_sat", bus.sat_out, 0);
        chk("rst_sat_cnt", sat_cnt, 0);
        rst_n = 1;
        #1;
        chk("rst_in_ready", bus.in_ready, 1);
        @(posedge clk);

        // directed table, one transaction at a time
        cycle(0, '0, '0, 0, 1, 0, 1, acc);
        for (int i = 0; i < 5; i++) begin
            cycle(1, tbl[i].q, tbl[i].r, tbl[i].off, 1, 0, 0, acc);
            chk("tbl_accept", acc, 1);
            c0 = obs_cnt;
            idle(1);
            chk("tbl_lat1_valid", obs_valid, 0);
            idle(1);
            chk("tbl_lat2_valid", obs_valid, 1);
            chk("tbl_sign", obs.sign, tbl[i].sign);
            chk("tbl_mag", obs.mag, tbl[i].mag);
            chk("tbl_sat", obs.sat, tbl[i].sat);
            chk("tbl_cnt_delta", 16'(obs_cnt - c0), $countones(tbl[i].sat));
            drain();
        end

        // backpressure: five back-to-back with out_ready low 4 cycles
        for (int i = 0; i < 5; i++) begin
            bq[i] = $urandom;
            br[i] = $urandom;
        end
        idx = 0;
        n0  = n_out;
        for (int t = 0; t < 40 && idx < 5; t++) begin
            cycle(1, bq[idx], br[idx], 0, t >= 4, 0, 0, acc);
            if (t == 2) chk("bp_in_ready_low", obs_ready, 0);
            if (acc) idx++;
            if (t == 3) chk("bp_accepts_stalled", idx, 2);
        end
        chk("bp_all_accepted", idx, 5);
        drain();
        chk("bp_all_out", n_out - n0, 5);

        // flush with two in flight and a competing input
        cycle(1, bq[0], br[0], 0, 0, 0, 0, acc);
        cycle(1, bq[1], br[1], 0, 0, 0, 0, acc);
        cycle(1, bq[2], br[2], 0, 0, 1, 0, acc);
        chk("flush_no_accept", acc, 0);
        idle(1);
        chk("flush_out_valid", obs_valid, 0);
        idle(1);
        chk("flush_out_valid2", obs_valid, 0);

        // clear beats a simultaneous saturated load
        chk("cnt_nonzero_before", obs_cnt != 0, 1);
        cycle(1, tbl[1].q, tbl[1].r, 0, 1, 0, 0, acc);
        cycle(0, '0, '0, 0, 1, 0, 1, acc);
        idle(1);
        chk("clr_prio_valid", obs_valid, 1);
        chk("clr_prio_cnt", obs_cnt, 0);
        drain();

        // randomized traffic against the model
        cycle(0, '0, '0, 0, 1, 0, 1, acc);
        exp_cnt = 0;
        n_acc   = 0;
        n_out   = 0;
        for (int t = 0; t < 400; t++) begin
            cycle($urandom_range(0, 9) < 7, $urandom, $urandom,
                  1'($urandom_range(0, 1)), $urandom_range(0, 9) < 6,
                  0, 0, acc);
        end
        drain();
        chk("rand_count", n_out, n_acc);
        chk("rand_sat_cnt", sat_cnt, exp_cnt);

        // reset mid-transaction discards in-flight data
        cycle(1, bq[3], br[3], 0, 0, 0, 0, acc);
        cycle(1, bq[4], br[4], 0, 0, 0, 0, acc);
        @(negedge clk);
        rst_n = 0;
        #1;
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_data", {bus.sign_out, bus.mag_out, bus.sat_out}, 0);
        chk("mid_rst_cnt", sat_cnt, 0);
        sb.delete();
        hold = 0;
        bus.in_valid = 0;
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        idle(1);
        chk("post_rst_in_ready", obs_ready, 1);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            chk("post_rst_no_out", obs_valid, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
